// File: rtl/apb_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master_if
// Purpose  : Bundles the command/response handshake and the APB bus of
//            apb_cmd_master into a single interface.
// Ports    : none (clock and reset stay scalar ports on the master).
//   command  : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata
//   response : rsp_valid/rsp_ready/rsp_rdata/rsp_err
//   APB      : psel/penable/pwrite/paddr/pwdata/prdata/pready
//   status   : busy
// Modports : master (the apb_cmd_master view), slave (the environment view).
// Revision : 1.0 - initial release
// ============================================================================
interface apb_cmd_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Purpose  : Turns single command requests into APB transfers (SETUP then
//            ACCESS) and returns one response per command. A transfer whose
//            slave keeps pready low for TIMEOUT ACCESS cycles is aborted with
//            rsp_err=1. At most one transfer is outstanding.
// Ports    : pclk   - clock, rising edge
//            preset - synchronous active-high reset
//            bus    - apb_cmd_master_if.master (command, response, APB, busy)
// Params   : TIMEOUT - ACCESS cycles with pready low before abort (1..255)
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
    parameter int TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             preset,
    apb_cmd_master_if.master bus
);

    // Wait-counter value seen on the TIMEOUT-th ACCESS cycle (the first
    // ACCESS cycle sees 0).
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t     state_q,     state_d;
    logic       pwrite_q,    pwrite_d;
    logic [7:0] paddr_q,     paddr_d;
    logic [7:0] pwdata_q,    pwdata_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q,   rsp_err_d;
    logic [7:0] wait_cnt_q,  wait_cnt_d;

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is high in IDLE, so cmd_valid alone is an accept.
                if (bus.cmd_valid) begin
                    state_d    = ST_SETUP;
                    pwrite_d   = bus.cmd_write;
                    paddr_d    = bus.cmd_addr;
                    pwdata_d   = bus.cmd_write ? bus.cmd_wdata : 8'h00;
                    wait_cnt_d = 8'h00;
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                wait_cnt_d = 8'h00;
            end
            ST_ACCESS: begin
                // pready wins over the timeout on the final allowed cycle.
                if (bus.pready) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = pwrite_q ? 8'h00 : bus.prdata;
                    rsp_err_d   = 1'b0;
                end else if (wait_cnt_q == C_WAIT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= 8'h00;
            pwdata_q    <= 8'h00;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Control outputs decode the state register only; no input reaches an
    // output combinationally.
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.penable   = (state_q == ST_ACCESS);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Purpose  : Self-checking bench for apb_cmd_master (TIMEOUT=4). A table of
//            single-transfer vectors plus hand-written sequences for response
//            back-pressure and reset during ACCESS.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    localparam int TMO = 4;

    logic pclk   = 1'b0;
    logic preset = 1'b1;

    apb_cmd_master_if bus ();

    apb_cmd_master #(.TIMEOUT(TMO)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus.master)
    );

    always #5 pclk = ~pclk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] prdata;
        int         waits;      // ACCESS cycles with pready low before it rises
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_acc;    // expected number of ACCESS cycles
    } vec_t;

    vec_t vecs [7];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Runs one complete transfer starting at a negedge with the DUT in IDLE.
    task automatic run_xfer(input vec_t v, input string tag);
        int         acc;
        logic [7:0] exp_pwdata;
        exp_pwdata = v.wr ? v.wdata : 8'h00;
        chk1({tag, " idle cmd_ready"}, bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        @(negedge pclk);
        // Scramble the command inputs to prove the DUT latched them.
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~v.wr;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        chk1({tag, " setup psel"},      bus.psel,      1'b1);
        chk1({tag, " setup penable"},   bus.penable,   1'b0);
        chk1({tag, " setup cmd_ready"}, bus.cmd_ready, 1'b0);
        chk1({tag, " setup busy"},      bus.busy,      1'b1);
        chk8({tag, " setup paddr"},     bus.paddr,     v.addr);
        chk1({tag, " setup pwrite"},    bus.pwrite,    v.wr);
        chk8({tag, " setup pwdata"},    bus.pwdata,    exp_pwdata);
        acc = 0;
        @(negedge pclk);
        for (int g = 0; g < 2 * TMO + 20 && bus.penable === 1'b1; g++) begin
            acc++;
            chk1({tag, " access psel"},   bus.psel,   1'b1);
            chk8({tag, " access paddr"},  bus.paddr,  v.addr);
            chk8({tag, " access pwdata"}, bus.pwdata, exp_pwdata);
            chk1({tag, " access pwrite"}, bus.pwrite, v.wr);
            if (acc > v.waits) begin
                bus.pready = 1'b1;
                bus.prdata = v.prdata;
            end else begin
                bus.pready = 1'b0;
                bus.prdata = 8'hEE;
            end
            @(negedge pclk);
        end
        bus.pready = 1'b0;
        bus.prdata = 8'h00;
        chki({tag, " access cycles"}, acc, v.exp_acc);
        chk1({tag, " resp rsp_valid"}, bus.rsp_valid, 1'b1);
        chk1({tag, " resp psel"},      bus.psel,      1'b0);
        chk1({tag, " resp penable"},   bus.penable,   1'b0);
        chk1({tag, " resp busy"},      bus.busy,      1'b1);
        chk8({tag, " resp rdata"},     bus.rsp_rdata, v.exp_rdata);
        chk1({tag, " resp err"},       bus.rsp_err,   v.exp_err);
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        chk1({tag, " done rsp_valid"}, bus.rsp_valid, 1'b0);
        chk1({tag, " done cmd_ready"}, bus.cmd_ready, 1'b1);
        chk1({tag, " done busy"},      bus.busy,      1'b0);
    endtask

    initial begin
        vec_t v03;

        //            wr    addr   wdata  prdata waits rdata  err  acc
        vecs[0] = '{1'b1, 8'h01, 8'h5A, 8'h00, 0,  8'h00, 1'b0, 1};
        vecs[1] = '{1'b0, 8'h02, 8'h00, 8'hC3, 3,  8'hC3, 1'b0, 4};
        vecs[2] = '{1'b0, 8'h10, 8'h12, 8'h55, 10, 8'h00, 1'b1, 4};
        vecs[3] = '{1'b0, 8'h11, 8'h34, 8'h77, 3,  8'h77, 1'b0, 4};
        vecs[4] = '{1'b1, 8'h20, 8'hFF, 8'h99, 2,  8'h00, 1'b0, 3};
        vecs[5] = '{1'b0, 8'h7F, 8'hEE, 8'hA5, 0,  8'hA5, 1'b0, 1};
        vecs[6] = '{1'b1, 8'h30, 8'h11, 8'h66, 4,  8'h00, 1'b1, 4};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        bus.prdata    = 8'h00;
        bus.pready    = 1'b0;

        // Reset: cmd_valid is asserted to show reset overrides it.
        preset = 1'b1;
        bus.cmd_valid = 1'b1;
        repeat (3) @(negedge pclk);
        chk1("reset psel",      bus.psel,      1'b0);
        chk1("reset penable",   bus.penable,   1'b0);
        chk1("reset pwrite",    bus.pwrite,    1'b0);
        chk1("reset rsp_valid", bus.rsp_valid, 1'b0);
        chk1("reset rsp_err",   bus.rsp_err,   1'b0);
        chk1("reset busy",      bus.busy,      1'b0);
        chk8("reset paddr",     bus.paddr,     8'h00);
        chk8("reset pwdata",    bus.pwdata,    8'h00);
        chk8("reset rsp_rdata", bus.rsp_rdata, 8'h00);
        bus.cmd_valid = 1'b0;
        preset = 1'b0;
        @(negedge pclk);
        chk1("post-reset cmd_ready", bus.cmd_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i], $sformatf("v%0d", i));
        end

        // Response back-pressure with a second command waiting.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h21;
        bus.cmd_wdata = 8'h00;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        bus.pready = 1'b1;
        bus.prdata = 8'h3C;
        @(negedge pclk);
        bus.pready    = 1'b0;
        bus.prdata    = 8'h00;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h40;
        bus.cmd_wdata = 8'h99;
        for (int k = 0; k < 5; k++) begin
            chk1($sformatf("bp%0d rsp_valid", k), bus.rsp_valid, 1'b1);
            chk8($sformatf("bp%0d rdata", k),     bus.rsp_rdata, 8'h3C);
            chk1($sformatf("bp%0d cmd_ready", k), bus.cmd_ready, 1'b0);
            chk1($sformatf("bp%0d psel", k),      bus.psel,      1'b0);
            @(negedge pclk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        chk1("bp hs rsp_valid", bus.rsp_valid, 1'b0);
        chk1("bp hs cmd_ready", bus.cmd_ready, 1'b1);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        chk1("bp2 psel",    bus.psel,    1'b1);
        chk1("bp2 penable", bus.penable, 1'b0);
        chk8("bp2 paddr",   bus.paddr,   8'h40);
        chk1("bp2 pwrite",  bus.pwrite,  1'b1);
        chk8("bp2 pwdata",  bus.pwdata,  8'h99);
        @(negedge pclk);
        chk1("bp2 access penable", bus.penable, 1'b1);
        bus.pready = 1'b1;
        @(negedge pclk);
        bus.pready = 1'b0;
        chk1("bp2 rsp_valid", bus.rsp_valid, 1'b1);
        chk1("bp2 rsp_err",   bus.rsp_err,   1'b0);
        chk8("bp2 rdata",     bus.rsp_rdata, 8'h00);
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        chk1("bp2 done cmd_ready", bus.cmd_ready, 1'b1);

        // Reset pulsed during ACCESS.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h50;
        bus.cmd_wdata = 8'h66;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        chk1("rst-acc penable before", bus.penable, 1'b1);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        chk1("rst-acc psel",      bus.psel,      1'b0);
        chk1("rst-acc penable",   bus.penable,   1'b0);
        chk1("rst-acc busy",      bus.busy,      1'b0);
        chk8("rst-acc paddr",     bus.paddr,     8'h00);
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("rst-acc%0d rsp_valid", k), bus.rsp_valid, 1'b0);
            @(negedge pclk);
        end
        v03 = '{1'b1, 8'h03, 8'hA7, 8'h00, 1, 8'h00, 1'b0, 2};
        run_xfer(v03, "post-rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 16, legal 1..255; number of consecutive ACCESS cycles with pready low before the transfer aborts.
REQ-002 pclk  in  1  single clock; all state updates on rising edge.
REQ-003 preset  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge.
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_addr  in  8  APB target address.
REQ-008 cmd_wdata  in  8  write data; ignored for reads.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at an edge.
REQ-011 rsp_rdata  out  8  read data; 0x00 for writes and for aborted transfers.
REQ-012 rsp_err  out  1  1 = transfer aborted by timeout.
REQ-013 psel, penable, pwrite  out  1 each  APB control to the timer slave.
REQ-014 paddr, pwdata  out  8 each  APB address and write data.
REQ-015 prdata  in  8, pready  in  1  APB slave response.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state registers only, no combinational path from any input to any output.
REQ-018 IDLE: cmd_ready=1, psel=0, penable=0; on accept, latch cmd_write/cmd_addr/cmd_wdata, go to SETUP.
REQ-019 SETUP: exactly one cycle, psel=1, penable=0, paddr/pwrite/pwdata = latched values; go to ACCESS unconditionally.
REQ-020 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held unchanged from SETUP until ACCESS exits.
REQ-021 ACCESS with pready=1 at an edge: capture prdata into rsp_rdata for reads (0x00 for writes), rsp_err=0, go to RESP.
REQ-022 ACCESS with pready=0: increment 8-bit wait counter (cleared on SETUP entry); if pready is still 0 on the TIMEOUT-th ACCESS cycle, go to RESP with rsp_err=1, rsp_rdata=0x00.
REQ-023 pready=1 on the TIMEOUT-th ACCESS cycle counts as success; pready takes priority over timeout.
REQ-024 RESP: psel=0, penable=0, rsp_valid=1; rsp_rdata and rsp_err held stable until handshake; on rsp_ready go to IDLE.
REQ-025 cmd_ready=0 in SETUP, ACCESS, RESP; commands presented there are not accepted and must be held by the source.
REQ-026 Minimum latency: accept at edge N -> psel at N+1 -> penable at N+2 -> rsp_valid at N+3 (zero-wait slave) -> cmd_ready again at N+4 if rsp_ready=1 at N+3.
REQ-027 A new command is never accepted while a response is pending; at most one transfer is outstanding.
REQ-028 pwdata driven 0x00 when the latched command is a read; paddr/pwdata/pwrite hold their last values in IDLE and RESP.

Reset
REQ-029 preset=1 at an edge: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err, busy = 0; paddr, pwdata, rsp_rdata = 0x00; wait counter = 0; cmd_ready=1 from the first cycle after reset releases.
REQ-030 Reset asserted in SETUP, ACCESS or RESP aborts the transfer: psel/penable drop at that edge, no response is ever produced for the in-flight command.
REQ-031 preset overrides all other inputs in the same cycle.

Verification
REQ-032 Write 0x5A to addr 0x01, pready tied 1 -> psel at N+1, penable at N+2, pwdata=0x5A, pwrite=1, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0x00.
REQ-033 Read addr 0x02, slave holds pready=0 for 3 ACCESS cycles then returns prdata=0xC3 -> penable high 4 cycles, rsp_rdata=0xC3, rsp_err=0, paddr stable at 0x02 throughout.
REQ-034 TIMEOUT=4, pready stuck 0 -> exactly 4 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0x00; pready=1 on the 4th cycle instead gives rsp_err=0.
REQ-035 rsp_ready held 0 for 5 cycles with second cmd_valid asserted -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; second command accepted the cycle after the response handshake.
REQ-036 preset pulsed during ACCESS -> next cycle psel=0, penable=0, busy=0, rsp_valid never asserts; following write to 0x03 completes normally.
